matmul_result_drain: RTL and testbench
======================================

// Module: matmul_result_drain
// PURPOSE
//   Downstream stage of the 3x3 matrix-multiply datapath. Accepts MAC result rows over a valid/ready
//   handshake and buffers one full NxN result matrix. Streams the elements out one per transfer,
//   row-major, to the host/output interface, narrowing each from ACC_W to OUT_W bits.
// PARAMETERS
//   N      3   matrix dimension (rows and columns)
//   ACC_W  10  width of each MAC result (4b x 4b products, sum of 3)
//   OUT_W  8   width of each streamed element; OUT_W <= ACC_W
// PORTS
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   flush      in   1        synchronous abort: discard buffer, return to FILL
//   row_valid  in   1        row_data holds one result row
//   row_ready  out  1        block accepts a row this cycle
//   row_data   in   N*ACC_W  row elements; element c is at [c*ACC_W +: ACC_W]
//   out_valid  out  1        out_data holds a valid element
//   out_ready  in   1        downstream accepts out_data this cycle
//   out_data   out  OUT_W    current element, narrowed
//   out_idx    out  4        row-major index of the current element, 0..N*N-1
//   out_last   out  1        high with out_valid on element N*N-1
//   busy       out  1        high while in DRAIN
//   sat_flag   out  1        sticky: some element exceeded OUT_W (RESULT_SAT_EN only)
// BEHAVIOUR
//   Reset values: all outputs 0 except row_ready=1 (FILL); row_cnt=0; elem_cnt=0; buffer contents don't-care.
//   Reset is legal mid-DRAIN. It takes effect immediately, and the partial matrix is lost.
//   FSM states: FILL, DRAIN.
//   FILL:
//     - row_ready=1.
//     - Row accepted when row_valid && row_ready. It is written to buffer row row_cnt, then row_cnt increments.
//     - Accepting row N-1 moves the FSM to DRAIN on the next edge and sets row_cnt=0.
//   DRAIN:
//     - row_ready=0 and busy=1. No row overlap with draining.
//     - out_valid=1 from the first DRAIN cycle. Latency: last row accepted at edge t, element 0 valid after edge t.
//     - out_data and out_idx are held stable while out_valid && !out_ready.
//     - Transfer when out_valid && out_ready: elem_cnt increments.
//     - Transfer of element N*N-1: FSM returns to FILL, out_valid=0 and row_ready=1 after that edge.
//       There is no bubble cycle beyond this.
//   flush:
//     - Highest priority over every handshake in the same cycle.
//     - Next state FILL; row_cnt=elem_cnt=0; out_valid=0; sat_flag cleared.
//     - A row offered in the flush cycle is dropped.
//     - An element with out_ready=1 in the flush cycle counts as consumed downstream, but no further elements follow.
//   Arithmetic: elements are unsigned. Element index = row*N + col; row = elem_cnt / N via separate row/col counters (no divider).
//   row_valid during DRAIN is ignored; it is not an error.
// CONFIGURATION
//   Macro RESULT_SAT_EN:
//   - Defined: each element is clamped. If value > 2^OUT_W-1, out_data = all ones and sat_flag sets (sticky until flush/reset).
//   - Undefined: out_data = value[OUT_W-1:0] (truncation), and sat_flag is tied 0.
//   - If OUT_W == ACC_W, both builds are a pass-through.
// STRUCTURE
//   matmul_defs.vh (shared with datapath/matmul):
//   - N, ACC_W, OUT_W defaults.
//   - FSM state encodings: FILL=1'b0, DRAIN=1'b1.
//   - Index width constant.
//   Sub-module result_narrow (combinational ACC_W->OUT_W):
//   - Holds the RESULT_SAT_EN clamp/truncate logic and outputs a per-element overflow bit.
//   Top level contains:
//   - N-row register buffer.
//   - row_cnt, and row/col drain counters.
//   - FSM.
//   - sat_flag register.
// TESTING
//   1. Rows {1,2,3},{4,5,6},{7,8,9}, out_ready=1:
//      out_data 1..9 on 9 consecutive cycles, out_idx 0..8, out_last only at idx 8;
//      row_ready=1 the cycle after.
//   2. Backpressure: out_ready toggles 1,0,0,1,...: each element held stable while stalled, no loss or duplication,
//      9 transfers total.
//   3. row_valid gapped 1-of-3 cycles in FILL: row_ready stays 1, out_valid first rises the cycle after the 3rd accept;
//      rows offered in DRAIN are not stored.
//   4. Element 300 (ACC_W=10, OUT_W=8): with RESULT_SAT_EN -> out_data=255 and sat_flag=1;
//      without -> out_data=44 and sat_flag=0.
//   5. flush asserted at elem 4 with out_ready=1:
//      next cycle out_valid=0, row_ready=1, sat_flag=0; a following fresh matrix drains from idx 0.
//   6. rst_n pulled low mid-DRAIN, asynchronously between edges: outputs go to reset values immediately;
//      after release, the block accepts a new matrix normally.

Source files
------------

// File: rtl/matmul_result_drain_pkg.sv
// Shared definitions for the matmul result drain stage: default sizes,
// FSM state encoding, element index width and a counter-width helper.
package matmul_result_drain_pkg;

  localparam int N_DEF     = 3;
  localparam int ACC_W_DEF = 10;
  localparam int OUT_W_DEF = 8;

  // Wide enough for a row-major index into a matrix of up to 4x4.
  localparam int IDX_W = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Width of a counter that walks 0..n-1; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_result_drain_if.sv
// Row-in / element-out handshake bundle of the matmul result drain stage.
// slave: the drain block itself; master: the row producer plus the output consumer.
interface matmul_result_drain_if
  import matmul_result_drain_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) ();

  logic                 row_valid;
  logic                 row_ready;
  logic [N*ACC_W-1:0]   row_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;

  modport slave (
    input  row_valid, row_data, out_ready,
    output row_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output row_valid, row_data, out_ready,
    input  row_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/matmul_result_drain_narrow.sv
// Combinational ACC_W -> OUT_W element narrowing.
// Build option RESULT_SAT_EN: when defined, values above 2^OUT_W-1 clamp to
// all ones; otherwise the upper bits are simply dropped. o_ovf flags any
// element that does not fit in OUT_W bits, in both builds.
module matmul_result_drain_narrow
  import matmul_result_drain_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] i_val,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf
);

  generate
    if (OUT_W == ACC_W) begin : g_pass
      assign o_data = i_val;
      assign o_ovf  = 1'b0;
    end else begin : g_narrow
      logic w_ovf;
      assign w_ovf = |i_val[ACC_W-1:OUT_W];
`ifdef RESULT_SAT_EN
      assign o_data = w_ovf ? {OUT_W{1'b1}} : i_val[OUT_W-1:0];
`else
      assign o_data = i_val[OUT_W-1:0];
`endif
      assign o_ovf = w_ovf;
    end
  endgenerate

endmodule

// File: rtl/matmul_result_drain.sv
// matmul_result_drain: buffers one NxN matrix of MAC results arriving a row
// at a time, then streams it out row-major one element per transfer,
// narrowed to OUT_W bits. Fill and drain never overlap.
// Build option RESULT_SAT_EN: clamp oversize elements and keep a sticky
// sat_flag; when undefined elements are truncated and sat_flag stays 0.
module matmul_result_drain
  import matmul_result_drain_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  matmul_result_drain_if.slave  bus,
  output logic                  busy,
  output logic                  sat_flag
);

  localparam int CNT_W = cnt_w(N);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_row_cnt;
  logic [CNT_W-1:0]       r_drow;
  logic [CNT_W-1:0]       r_dcol;
  logic [N*ACC_W-1:0]     r_buf [N];

  logic                   w_row_acc;
  logic                   w_row_last;
  logic                   w_xfer;
  logic                   w_elem_last;
  logic [N*ACC_W-1:0]     w_sel_row;
  logic [ACC_W-1:0]       w_elem;
  logic [OUT_W-1:0]       w_narrow;
  logic                   w_ovf;
  logic [IDX_W-1:0]       w_idx;

  // Handshakes are qualified by state so rows offered in DRAIN are ignored.
  assign w_row_acc   = bus.row_valid && (r_state == FILL);
  assign w_row_last  = (r_row_cnt == CNT_W'(N - 1));
  assign w_xfer      = bus.out_ready && (r_state == DRAIN);
  assign w_elem_last = (r_drow == CNT_W'(N - 1)) && (r_dcol == CNT_W'(N - 1));

  // Element select from separate row/col counters keeps the index free of a divider.
  assign w_sel_row = r_buf[r_drow];
  assign w_elem    = w_sel_row[int'(r_dcol) * ACC_W +: ACC_W];
  assign w_idx     = IDX_W'(r_drow) * IDX_W'(N) + IDX_W'(r_dcol);

  matmul_result_drain_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_narrow (
    .i_val  (w_elem),
    .o_data (w_narrow),
    .o_ovf  (w_ovf)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; flush overrides every handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_row_acc && w_row_last) w_state_nxt = DRAIN;
        DRAIN:   if (w_xfer && w_elem_last)  w_state_nxt = FILL;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  // FSM outputs; data outputs read zero whenever nothing is being offered.
  always_comb begin
    bus.row_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    case (r_state)
      FILL: begin
        bus.row_ready = 1'b1;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = w_narrow;
        bus.out_idx   = w_idx;
        bus.out_last  = w_elem_last;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  // Fill row counter and drain row/col counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
      r_drow    <= '0;
      r_dcol    <= '0;
    end else if (flush) begin
      r_row_cnt <= '0;
      r_drow    <= '0;
      r_dcol    <= '0;
    end else begin
      if (w_row_acc) begin
        r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
      end
      if (w_xfer) begin
        if (r_dcol == CNT_W'(N - 1)) begin
          r_dcol <= '0;
          r_drow <= (r_drow == CNT_W'(N - 1)) ? '0 : r_drow + 1'b1;
        end else begin
          r_dcol <= r_dcol + 1'b1;
        end
      end
    end
  end

  // Matrix buffer: data only, so no reset; a flushed row is never written.
  always_ff @(posedge clk) begin
    if (w_row_acc && !flush) r_buf[r_row_cnt] <= bus.row_data;
  end

`ifdef RESULT_SAT_EN
  // Sticky saturation flag, set when a clamped element is handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sat_flag <= 1'b0;
    else if (flush)             sat_flag <= 1'b0;
    else if (w_xfer && w_ovf)   sat_flag <= 1'b1;
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign sat_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain: table of matrices with expected
// streamed elements, plus hand sequences for backpressure, gapped rows,
// flush and asynchronous reset. Expected values follow RESULT_SAT_EN.
module tb_matmul_result_drain;

  localparam int N     = 3;
  localparam int ACC_W = 10;
  localparam int OUT_W = 8;

`ifdef RESULT_SAT_EN
  localparam int SAT_BUILD = 1;
`else
  localparam int SAT_BUILD = 0;
`endif

  typedef struct packed {
    logic [8:0][9:0] elem;
    logic [8:0][7:0] expo;
    logic            exp_sat;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  logic sat_flag;

  int total = 0;
  int bad   = 0;

  vec_t vecs [3];

  int ev [3][9] = '{'{1, 2, 3, 4, 5, 6, 7, 8, 9},
                    '{300, 0, 255, 256, 1023, 44, 511, 128, 767},
                    '{10, 20, 30, 40, 50, 60, 70, 80, 90}};
`ifdef RESULT_SAT_EN
  int xv [3][9] = '{'{1, 2, 3, 4, 5, 6, 7, 8, 9},
                    '{255, 0, 255, 255, 255, 44, 255, 128, 255},
                    '{10, 20, 30, 40, 50, 60, 70, 80, 90}};
  int xs [3]    = '{0, 1, 1};
`else
  int xv [3][9] = '{'{1, 2, 3, 4, 5, 6, 7, 8, 9},
                    '{44, 0, 255, 0, 255, 44, 255, 128, 255},
                    '{10, 20, 30, 40, 50, 60, 70, 80, 90}};
  int xs [3]    = '{0, 0, 0};
`endif

  matmul_result_drain_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  matmul_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .busy     (busy),
    .sat_flag (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*ACC_W-1:0] row_of(input int vi, input int r);
    return {vecs[vi].elem[3*r+2], vecs[vi].elem[3*r+1], vecs[vi].elem[3*r]};
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic send_matrix(input int vi);
    for (int r = 0; r < N; r++) begin
      bus.row_valid = 1'b1;
      bus.row_data  = row_of(vi, r);
      #1;
      chk("fill_row_ready", int'(bus.row_ready), 1);
      chk("fill_out_valid", int'(bus.out_valid), 0);
      @(posedge clk); #1;
    end
    bus.row_valid = 1'b0;
    chk("first_elem_latency", int'(bus.out_valid), 1);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready 1,0,0,1,0,0,...
  task automatic drain(input int vi, input int mode, input bit junk,
                       input int stop, output int ncyc);
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    while (n < stop && cyc < 200) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      bus.row_valid = junk;
      if (junk) bus.row_data = '1;
      #1;
      chk("drain_valid",     int'(bus.out_valid), 1);
      chk("drain_busy",      int'(busy), 1);
      chk("drain_row_ready", int'(bus.row_ready), 0);
      chk("drain_data",      int'(bus.out_data), int'(vecs[vi].expo[n]));
      chk("drain_idx",       int'(bus.out_idx), n);
      chk("drain_last",      int'(bus.out_last), int'(n == 8));
      if (bus.out_ready) n++;
      cyc++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    bus.row_valid = 1'b0;
    chk("drain_transfers", n, stop);
    ncyc = cyc;
  endtask

  task automatic chk_idle(input string tag, input int exp_sat);
    chk({tag, "_row_ready"}, int'(bus.row_ready), 1);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_out_data"},  int'(bus.out_data), 0);
    chk({tag, "_out_idx"},   int'(bus.out_idx), 0);
    chk({tag, "_out_last"},  int'(bus.out_last), 0);
    chk({tag, "_sat_flag"},  int'(sat_flag), exp_sat);
  endtask

  initial begin
    int nc;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) begin
        vecs[k].elem[i] = 10'(ev[k][i]);
        vecs[k].expo[i] = 8'(xv[k][i]);
      end
      vecs[k].exp_sat = xs[k][0];
    end

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.out_ready = 1'b0;
    #1;
    chk_idle("reset", 0);
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_reset", 0);

    // Table: full matrices, out_ready held high, 9 back-to-back transfers.
    for (int vi = 0; vi < 3; vi++) begin
      send_matrix(vi);
      drain(vi, 0, 1'b0, 9, nc);
      chk("burst_cycles", nc, 9);
      chk("after_row_ready", int'(bus.row_ready), 1);
      chk("after_out_valid", int'(bus.out_valid), 0);
      chk("table_sat_flag", int'(sat_flag), int'(vecs[vi].exp_sat));
    end

    // Backpressure 1,0,0,...: 9 transfers spread over 25 cycles.
    send_matrix(0);
    drain(0, 1, 1'b0, 9, nc);
    chk("bp_cycles", nc, 25);
    chk("bp_after_row_ready", int'(bus.row_ready), 1);

    // Gapped rows, then rows offered while draining must not be stored.
    for (int c = 0; c < 7; c++) begin
      bus.row_valid = ((c % 3) == 0);
      bus.row_data  = row_of(2, c / 3);
      #1;
      chk("gap_row_ready", int'(bus.row_ready), 1);
      chk("gap_out_valid", int'(bus.out_valid), 0);
      @(posedge clk); #1;
    end
    bus.row_valid = 1'b0;
    chk("gap_latency", int'(bus.out_valid), 1);
    drain(2, 0, 1'b1, 9, nc);
    send_matrix(0);
    drain(0, 0, 1'b0, 9, nc);
    chk("post_gap_cycles", nc, 9);

    // Flush while element 4 is being taken.
    send_matrix(1);
    drain(1, 0, 1'b0, 4, nc);
    chk("pre_flush_sat", int'(sat_flag), SAT_BUILD);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    bus.row_valid = 1'b1;
    bus.row_data  = '1;
    #1;
    chk("flush_idx", int'(bus.out_idx), 4);
    chk("flush_data", int'(bus.out_data), int'(vecs[1].expo[4]));
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    bus.row_valid = 1'b0;
    chk_idle("flush", 0);
    send_matrix(0);
    drain(0, 0, 1'b0, 9, nc);
    chk("post_flush_cycles", nc, 9);

    // Asynchronous reset in the middle of a drain.
    send_matrix(1);
    drain(1, 0, 1'b0, 2, nc);
    chk("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst_release", 0);
    send_matrix(2);
    drain(2, 0, 1'b0, 9, nc);
    chk("post_rst_cycles", nc, 9);
    chk("post_rst_row_ready", int'(bus.row_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
